// File: rtl/dcache_direct_pkg.sv
// Shared definitions for the direct-mapped data cache: default geometry,
// derived address-field widths and the miss-handling state encoding.
package dcache_direct_pkg;

  localparam int WORD_SIZE_DEF  = 16;
  localparam int NUM_LINES_DEF  = 8;
  localparam int LINE_WORDS_DEF = 4;

  localparam int OFFSET_BITS = $clog2(LINE_WORDS_DEF);
  localparam int INDEX_BITS  = $clog2(NUM_LINES_DEF);
  localparam int TAG_BITS    = WORD_SIZE_DEF - OFFSET_BITS - INDEX_BITS;
  localparam int LINE_BITS   = WORD_SIZE_DEF * LINE_WORDS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the direct-mapped cache: valid/dirty/tag/data per line,
// one combinational read port, and a posedge write of either one word
// (store hit, marks the line dirty) or a whole line (fill, marks it clean).
module dcache_array
  import dcache_direct_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [$clog2(NUM_LINES)-1:0]     rd_index,
  output logic                             rd_valid,
  output logic                             rd_dirty,
  output logic [WORD_SIZE-$clog2(LINE_WORDS)-$clog2(NUM_LINES)-1:0] rd_tag,
  output logic [WORD_SIZE*LINE_WORDS-1:0]  rd_line,
  input  logic                             word_we,
  input  logic [$clog2(NUM_LINES)-1:0]     word_index,
  input  logic [$clog2(LINE_WORDS)-1:0]    word_offset,
  input  logic [WORD_SIZE-1:0]             word_data,
  input  logic                             line_we,
  input  logic [$clog2(NUM_LINES)-1:0]     line_index,
  input  logic [WORD_SIZE-$clog2(LINE_WORDS)-$clog2(NUM_LINES)-1:0] line_tag,
  input  logic [WORD_SIZE*LINE_WORDS-1:0]  line_data
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = WORD_SIZE - OB - IB;
  localparam int LB = WORD_SIZE * LINE_WORDS;

  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [TB-1:0]        tag_r  [NUM_LINES];
  logic [LB-1:0]        data_r [NUM_LINES];

  assign rd_valid = valid_r[rd_index];
  assign rd_dirty = dirty_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_line  = data_r[rd_index];

  // Storage update: clear on reset, install a fetched line, or merge a stored word.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      valid_r <= {NUM_LINES{1'b0}};
      dirty_r <= {NUM_LINES{1'b0}};
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_r[i]  <= {TB{1'b0}};
        data_r[i] <= {LB{1'b0}};
      end
    end else if (line_we) begin
      valid_r[line_index] <= 1'b1;
      dirty_r[line_index] <= 1'b0;
      tag_r[line_index]   <= line_tag;
      data_r[line_index]  <= line_data;
    end else if (word_we) begin
      data_r[word_index][int'(word_offset)*WORD_SIZE +: WORD_SIZE] <= word_data;
      dirty_r[word_index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_direct_chk.sv
// Protocol checker for the CPU side of the cache: a load and a store must
// never be requested in the same cycle.
module dcache_direct_chk (
  input logic clk,
  input logic reset_n,
  input logic cpu_read,
  input logic cpu_write
);

  rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset_n) !(cpu_read && cpu_write));

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-back, write-allocate data cache. Hits are answered
// combinationally; misses stall the CPU while a dirty victim is written back
// and the requested line is fetched. Hit/miss counters for performance.
module dcache_direct
  import dcache_direct_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int NUM_LINES  = NUM_LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic [WORD_SIZE-1:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]            cpu_wdata,
  output logic [WORD_SIZE-1:0]            cpu_rdata,
  output logic                            cpu_ready,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            mem_ready,
  output logic [WORD_SIZE-1:0]            hit_count,
  output logic [WORD_SIZE-1:0]            miss_count
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TB = WORD_SIZE - OB - IB;
  localparam int LB = WORD_SIZE * LINE_WORDS;
  localparam logic [WORD_SIZE-1:0] ONE_W = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_e state_r, state_nxt_s;

  logic [IB-1:0]        miss_idx_r;
  logic [TB-1:0]        miss_tag_r;
  logic                 miss_pending_r;
  logic [WORD_SIZE-1:0] hit_count_r, miss_count_r;
  logic                 mem_req_r, mem_we_r;
  logic [WORD_SIZE-1:0] mem_addr_r;
  logic [LB-1:0]        mem_wdata_r;

  logic [OB-1:0]        cpu_off_s;
  logic [IB-1:0]        cpu_idx_s, arr_idx_s;
  logic [TB-1:0]        cpu_tag_s, line_tag_s;
  logic                 line_valid_s, line_dirty_s;
  logic [LB-1:0]        line_data_s;
  logic                 req_s, hit_s, victim_dirty_s;
  logic                 cpu_ready_s, word_we_s, line_we_s, miss_start_s, hit_done_s;
  logic [WORD_SIZE-1:0] cpu_rdata_s;

  assign cpu_off_s = cpu_addr[OB-1:0];
  assign cpu_idx_s = cpu_addr[OB +: IB];
  assign cpu_tag_s = cpu_addr[WORD_SIZE-1 -: TB];

  // While a miss is outstanding the array is looked up at the latched index,
  // so the victim line stays visible even if the CPU address changes.
  assign arr_idx_s      = (state_r == ST_IDLE) ? cpu_idx_s : miss_idx_r;
  assign req_s          = cpu_read | cpu_write;
  assign hit_s          = line_valid_s && (line_tag_s == cpu_tag_s);
  assign victim_dirty_s = line_valid_s && line_dirty_s;

  dcache_array #(
    .WORD_SIZE  (WORD_SIZE),
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_index    (arr_idx_s),
    .rd_valid    (line_valid_s),
    .rd_dirty    (line_dirty_s),
    .rd_tag      (line_tag_s),
    .rd_line     (line_data_s),
    .word_we     (word_we_s),
    .word_index  (cpu_idx_s),
    .word_offset (cpu_off_s),
    .word_data   (cpu_wdata),
    .line_we     (line_we_s),
    .line_index  (miss_idx_r),
    .line_tag    (miss_tag_r),
    .line_data   (mem_rdata)
  );

  dcache_direct_chk u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write)
  );

  // Next-state and CPU-side response: serve hits, start misses, end transfers.
  always_comb begin
    state_nxt_s  = state_r;
    cpu_ready_s  = 1'b0;
    cpu_rdata_s  = {WORD_SIZE{1'b0}};
    word_we_s    = 1'b0;
    line_we_s    = 1'b0;
    miss_start_s = 1'b0;
    hit_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (hit_s) begin
            cpu_ready_s = 1'b1;
            hit_done_s  = 1'b1;
            word_we_s   = cpu_write;
            if (cpu_read) begin
              cpu_rdata_s = line_data_s[int'(cpu_off_s)*WORD_SIZE +: WORD_SIZE];
            end else begin
              cpu_rdata_s = {WORD_SIZE{1'b0}};
            end
          end else begin
            miss_start_s = 1'b1;
            if (victim_dirty_s) begin
              state_nxt_s = ST_WB;
            end else begin
              state_nxt_s = ST_FILL;
            end
          end
        end else begin
          cpu_ready_s = 1'b1;
        end
      end
      ST_WB: begin
        if (mem_ready) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_FILL: begin
        if (mem_ready) begin
          line_we_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and the index/tag of the miss being serviced.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_r    <= ST_IDLE;
      miss_idx_r <= {IB{1'b0}};
      miss_tag_r <= {TB{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (miss_start_s) begin
        miss_idx_r <= cpu_idx_s;
        miss_tag_r <= cpu_tag_s;
      end
    end
  end

  // Memory request registers: set up write-back or fill, hold stable until mem_ready.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {WORD_SIZE{1'b0}};
      mem_wdata_r <= {LB{1'b0}};
    end else if (miss_start_s) begin
      mem_req_r <= 1'b1;
      mem_we_r  <= victim_dirty_s;
      if (victim_dirty_s) begin
        mem_addr_r  <= {line_tag_s, cpu_idx_s, {OB{1'b0}}};
        mem_wdata_r <= line_data_s;
      end else begin
        mem_addr_r  <= {cpu_tag_s, cpu_idx_s, {OB{1'b0}}};
        mem_wdata_r <= {LB{1'b0}};
      end
    end else if ((state_r == ST_WB) && mem_ready) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {miss_tag_r, miss_idx_r, {OB{1'b0}}};
      mem_wdata_r <= {LB{1'b0}};
    end else if ((state_r == ST_FILL) && mem_ready) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {WORD_SIZE{1'b0}};
      mem_wdata_r <= {LB{1'b0}};
    end
  end

  // Performance counters; the hit that retires a miss is not counted as a hit.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      hit_count_r    <= {WORD_SIZE{1'b0}};
      miss_count_r   <= {WORD_SIZE{1'b0}};
      miss_pending_r <= 1'b0;
    end else if (miss_start_s) begin
      miss_count_r   <= miss_count_r + ONE_W;
      miss_pending_r <= 1'b1;
    end else if (hit_done_s) begin
      if (miss_pending_r) begin
        miss_pending_r <= 1'b0;
      end else begin
        hit_count_r <= hit_count_r + ONE_W;
      end
    end else if ((state_r == ST_IDLE) && !req_s) begin
      // Request was abandoned during the miss: no retry is coming.
      miss_pending_r <= 1'b0;
    end
  end

  assign cpu_ready  = cpu_ready_s;
  assign cpu_rdata  = cpu_rdata_s;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench for dcache_direct. A reference model (flat shadow memory
// plus per-index tag/valid/dirty bookkeeping) predicts read data, memory
// transfers, stall lengths and counters; monitors compare as the DUT responds.
module tb_dcache_direct;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_wdata = 16'h0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = 64'h0;
  logic        mem_ready = 1'b0;
  logic [15:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_direct dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [63:0] data;
  } mexp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] bmem   [0:65535];
  logic [15:0] shadow [0:65535];
  mexp_t       exp_mem_q[$];
  logic [15:0] exp_rd_q[$];
  bit          mv [8];
  bit          md [8];
  int          mt [8];
  int          m_hits = 0, m_misses = 0;
  int          lat_cfg = 4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] shadow_line(input int base);
    return {shadow[base+3], shadow[base+2], shadow[base+1], shadow[base]};
  endfunction

  function automatic bit model_hit(input logic [15:0] a);
    int idx = (int'(a) / 4) % 8;
    return mv[idx] && (mt[idx] == int'(a) / 32);
  endfunction

  // Reference model of one access: predicts transfers, stall length, data, counters.
  task automatic model_access(input bit rd, input bit wr, input logic [15:0] a,
                              input logic [15:0] d, input int lat, input bit push_rd,
                              output int exp_low);
    int idx  = (int'(a) / 4) % 8;
    int tag  = int'(a) / 32;
    int base = int'(a) - int'(a) % 4;
    int vb;
    logic [15:0] vaddr;
    logic [15:0] baddr;
    if (model_hit(a)) begin
      m_hits++;
      exp_low = 0;
    end else begin
      m_misses++;
      exp_low = 1 + lat;
      if (mv[idx] && md[idx]) begin
        vb    = mt[idx] * 32 + idx * 4;
        vaddr = vb[15:0];
        exp_mem_q.push_back('{1'b1, vaddr, shadow_line(vb)});
        exp_low += lat;
      end
      baddr = base[15:0];
      exp_mem_q.push_back('{1'b0, baddr, 64'h0});
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tag;
    end
    if (wr) begin
      shadow[a] = d;
      md[idx]   = 1'b1;
    end
    if (rd && push_rd) exp_rd_q.push_back(shadow[a]);
  endtask

  // Backing memory: checks each transfer against the scoreboard, answers after lat_cfg cycles.
  int          r_busy = 0, r_cnt = 0, r_lat = 1;
  logic [15:0] r_addr;
  logic        r_we;
  always @(negedge clk) begin
    mexp_t e;
    mem_ready = 1'b0;
    mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    if (mem_req) begin
      if (r_busy == 0) begin
        r_busy = 1; r_cnt = 1; r_lat = lat_cfg; r_addr = mem_addr; r_we = mem_we;
        if (exp_mem_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL mem_unexpected: got request addr %0h we %0b expected none", mem_addr, mem_we);
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_we", {63'h0, mem_we}, {63'h0, e.we});
          check("mem_addr", {48'h0, mem_addr}, {48'h0, e.addr});
          if (e.we) check("mem_wdata", mem_wdata, e.data);
        end
      end else begin
        r_cnt++;
        check("mem_addr_stable", {48'h0, mem_addr}, {48'h0, r_addr});
        check("mem_we_stable", {63'h0, mem_we}, {63'h0, r_we});
      end
      if (r_cnt >= r_lat) begin
        mem_ready = 1'b1;
        r_busy = 0;
        if (mem_we) begin
          for (int k = 0; k < 4; k++) bmem[int'(mem_addr) + k] = mem_wdata[k*16 +: 16];
        end else begin
          mem_rdata = {bmem[int'(mem_addr)+3], bmem[int'(mem_addr)+2],
                       bmem[int'(mem_addr)+1], bmem[int'(mem_addr)]};
        end
      end
    end else begin
      r_busy = 0;
    end
  end

  // Load-data monitor: every completed read is compared with the next predicted value.
  always @(negedge clk) begin
    if (!reset_n && cpu_read && cpu_ready) begin
      if (exp_rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rdata_unexpected: got %0h expected no read", cpu_rdata);
      end else begin
        check("cpu_rdata", {48'h0, cpu_rdata}, {48'h0, exp_rd_q.pop_front()});
      end
    end
  end

  task automatic check_counts();
    check("hit_count", {48'h0, hit_count}, m_hits[15:0]);
    check("miss_count", {48'h0, miss_count}, m_misses[15:0]);
  endtask

  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input int lat);
    int exp_low, low;
    bit done;
    lat_cfg = lat;
    model_access(rd, wr, a, d, lat, 1'b1, exp_low);
    @(posedge clk); #1;
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    low = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (cpu_ready) done = 1'b1;
      else low++;
    end
    check("access_done", {63'h0, done}, 64'h1);
    check("stall_cycles", low, exp_low);
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    check_counts();
  endtask

  // Read miss whose request is withdrawn during the fill.
  task automatic access_drop(input logic [15:0] a, input int lat);
    int exp_low;
    bit seen, idle;
    lat_cfg = lat;
    model_access(1'b1, 1'b0, a, 16'h0, lat, 1'b0, exp_low);
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_addr = a;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) seen = 1'b1;
    end
    check("drop_fill_seen", {63'h0, seen}, 64'h1);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    idle = 1'b0;
    for (int c = 0; c < 100 && !idle; c++) begin
      @(negedge clk);
      if (!mem_req) idle = 1'b1;
    end
    check("drop_fill_done", {63'h0, idle}, 64'h1);
    @(posedge clk); #1;
    check_counts();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"}, {63'h0, cpu_ready}, 64'h1);
    check({tag, "_mem_req"}, {63'h0, mem_req}, 64'h0);
    check({tag, "_mem_we"}, {63'h0, mem_we}, 64'h0);
    check({tag, "_mem_addr"}, {48'h0, mem_addr}, 64'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    check({tag, "_cpu_rdata"}, {48'h0, cpu_rdata}, 64'h0);
    check({tag, "_hit_count"}, {48'h0, hit_count}, 64'h0);
    check({tag, "_miss_count"}, {48'h0, miss_count}, 64'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 0; end
    m_hits = 0; m_misses = 0;
    shadow = bmem;
  endtask

  initial begin
    bit seen;
    int r;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) bmem[i] = 16'(i * 40503) ^ 16'h3C5A;
    bmem[16] = 16'h000A; bmem[17] = 16'h000B; bmem[18] = 16'h000C; bmem[19] = 16'h000D;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b0;

    // Directed sequence
    access(1'b1, 1'b0, 16'h0013, 16'h0, 4);      // cold miss, FILL 0x0010, 5 stall cycles, D
    access(1'b1, 1'b0, 16'h0011, 16'h0, 4);      // hit, B
    access(1'b0, 1'b1, 16'h0012, 16'h1234, 4);   // write hit, line dirty
    access(1'b1, 1'b0, 16'h0032, 16'h0, 3);      // WB 0x0010 then FILL 0x0030
    access(1'b1, 1'b0, 16'h0050, 16'h0, 2);      // clean victim, FILL only

    // Reset in the middle of a fill
    lat_cfg = 8;
    exp_mem_q.push_back('{1'b0, 16'h0090, 64'h0});
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_addr = 16'h0090;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) seen = 1'b1;
    end
    check("rst_fill_seen", {63'h0, seen}, 64'h1);
    @(negedge clk);
    reset_n = 1'b1; cpu_read = 1'b0;
    #1;
    check_reset_outputs("midfill_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b0;
    access(1'b1, 1'b0, 16'h0010, 16'h0, 4);      // misses again, A
    access(1'b1, 1'b0, 16'h0012, 16'h0, 1);      // hit, written-back 0x1234

    // Request withdrawn during the fill, then a hit on that line
    access_drop(16'h00A8, 3);
    access(1'b1, 1'b0, 16'h00A9, 16'h0, 2);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      a = 16'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r < 5) access(1'b1, 1'b0, a, 16'h0, $urandom_range(1, 4));
      else if (r < 9) access(1'b0, 1'b1, a, 16'($urandom), $urandom_range(1, 4));
      else if (!model_hit(a)) access_drop(a, $urandom_range(1, 4));
      else access(1'b1, 1'b0, a, 16'h0, 1);
    end

    repeat (3) @(negedge clk);
    check("rd_queue_drained", exp_rd_q.size(), 64'h0);
    check("mem_queue_drained", exp_mem_q.size(), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_direct.md
Name: dcache_direct

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM-stage port (read_m2/write_m2/address2/data2) and the multi-cycle backing memory.
- Serves hits combinationally in the same cycle.
- On a miss, stalls the pipeline through cpu_ready=0 while it writes back a dirty victim line and fills the new line.
- Counts hits and misses for performance reporting.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- NUM_LINES, 8, number of cache lines (power of 2).
- LINE_WORDS, 4, words per line (power of 2).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset_n  input  1  asynchronous, active-high reset.
- cpu_read  input  1  load request from the MEM stage.
- cpu_write  input  1  store request from the MEM stage.
- cpu_addr  input  WORD_SIZE  word address.
- cpu_wdata  input  WORD_SIZE  store data.
- cpu_rdata  output  WORD_SIZE  load data; valid when cpu_ready=1 and cpu_read=1.
- cpu_ready  output  1  access completes this cycle; 0 means stall the pipeline.
- mem_req  output  1  line transfer request to backing memory.
- mem_we  output  1  1 = line write-back, 0 = line fill.
- mem_addr  output  WORD_SIZE  line-aligned word address (offset bits zero).
- mem_wdata  output  WORD_SIZE*LINE_WORDS  victim line; word 0 in the LSBs.
- mem_rdata  input  WORD_SIZE*LINE_WORDS  fill line; same word order.
- mem_ready  input  1  one-cycle pulse: the transfer completes at this posedge.
- hit_count  output  WORD_SIZE  completed accesses that hit.
- miss_count  output  WORD_SIZE  accesses that missed.

Behaviour:
- Address split for defaults:
  - offset = cpu_addr[1:0]
  - index = cpu_addr[4:2]
  - tag = cpu_addr[15:5]
  - In general: log2(LINE_WORDS) offset bits, log2(NUM_LINES) index bits, remaining bits are tag.
- Per-line state: valid, dirty, tag, LINE_WORDS data words.
- Reset (asynchronous, on reset_n=1):
  - All valid and dirty bits cleared; state=IDLE; counters=0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_ready=1.
  - Reset during WB or FILL aborts the transfer immediately; no line is installed.
- hit = valid[index] && tag match. State machine:
  - IDLE, no request: cpu_ready=1, memory idle.
  - IDLE, hit read: cpu_ready=1 and cpu_rdata=word[offset], both combinational (zero added latency).
  - IDLE, hit write: cpu_ready=1; the word is written and dirty set at the posedge.
  - IDLE, miss with a clean or invalid victim: cpu_ready=0; next state FILL.
  - IDLE, miss with a dirty victim: cpu_ready=0; next state WB.
  - WB: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line. On mem_ready, next state FILL.
  - FILL: mem_req=1, mem_we=0, mem_addr={request tag, index, 0}. On mem_ready: install line (valid=1, dirty=0, tag updated), next state IDLE.
  - The retried access then hits in IDLE. Miss latency = write-back cycles + fill cycles + 1.
- mem_addr, mem_we and mem_wdata hold stable while mem_req=1. mem_req deasserts in the cycle after mem_ready.
- cpu_ready=0 in WB and FILL regardless of the request.
- The CPU holds cpu_read, cpu_write, cpu_addr and cpu_wdata stable while cpu_ready=0. If the request drops mid-miss, the transfer still completes and the line is installed; then IDLE.
- cpu_read=1 and cpu_write=1 together is illegal. The write is honoured; a simulation assertion fires.
- Counters:
  - miss_count increments once on the IDLE→WB/FILL transition.
  - hit_count increments on an IDLE hit only when the access is not the retry of a miss (tracked by a miss_pending flag, cleared when that retry completes).
  - Both counters wrap modulo 2^WORD_SIZE.
- No flush port. Dirty lines remain until evicted.

Decomposition:
- Shared package (existing env/util header):
  - State encoding: IDLE, WB, FILL.
  - Field-width localparams: OFFSET_BITS, INDEX_BITS, TAG_BITS.
  - Line-width macro: WORD_SIZE*LINE_WORDS.
- One natural sub-module: dcache_array, holding valid/dirty/tag/data storage with a combinational read and a posedge write of a word or a whole line.
- FSM and counters stay in dcache_direct.

Test Plan:
- Cold read 0x0013, memory line 0x0010..0x0013 = {A,B,C,D}, mem_ready 4 cycles after mem_req → one FILL with mem_addr=0x0010; cpu_ready low for 5 cycles; then cpu_rdata=D; miss_count=1, hit_count=0.
- Read 0x0011 right after → cpu_ready=1 the same cycle, cpu_rdata=B, hit_count=1, no mem_req.
- Write 0x1234 to 0x0012 (hit), then read 0x0032 (same index 4, different tag) → WB with mem_addr=0x0010 and mem_wdata word2=0x1234, then FILL with mem_addr=0x0030; miss_count=2.
- Read 0x0050 (clean victim) → no WB; FILL only.
- Assert reset_n mid-FILL → mem_req=0 immediately, cpu_ready=1, counters=0; a following read of 0x0010 misses again.
- Drop cpu_read during FILL → the line is still installed; the next read of the same line hits with no mem_req.
